// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer and the CSR/trap unit.
//   pipe_state_e : sequencer state
//   trap_cause_e : encoding of trap_cause (exception vs interrupt)
//   HOLD_NOP / HOLD_PASS : polarity of the hold_* outputs
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_TRAP     = 2'd2,
    ST_SLEEP    = 2'd3
  } pipe_state_e;

  typedef enum logic {
    CAUSE_EXC = 1'b0,
    CAUSE_IRQ = 1'b1
  } trap_cause_e;

  // hold_* = 1 loads a NOP (bubble) into the pipeline register.
  localparam logic HOLD_NOP  = 1'b1;
  localparam logic HOLD_PASS = 1'b0;

endpackage : pipe_ctrl_pkg

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the rd of a load in EX.
// Ports: rs1_id/rs2_id/rs_used_id describe the ID reads; rd_id_ex/load_id_ex describe EX;
//        hazard_o is purely combinational. Writes to x0 never create a hazard.
module load_use_detect (
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic [1:0] rs_used_id,
  input  logic [4:0] rd_id_ex,
  input  logic       load_id_ex,
  output logic       hazard_o
);

  logic rd_nonzero;
  logic rs1_hit;
  logic rs2_hit;

  assign rd_nonzero = (rd_id_ex != 5'd0);
  assign rs1_hit    = rs_used_id[0] && (rs1_id == rd_id_ex);
  assign rs2_hit    = rs_used_id[1] && (rs2_id == rd_id_ex);
  assign hazard_o   = load_id_ex && rd_nonzero && (rs1_hit || rs2_hit);

endmodule : load_use_detect

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use bubbles, EX jumps, memory wait,
// trap entry (exception/IRQ) and WFI sleep. Outputs are combinational from state and inputs.
// Ports: hazard/status inputs from ID/EX, trap handshake (trap_req/trap_ack/trap_vec),
//        stall_n_*/hold_* to the pipeline registers, pc_load/pc_load_addr to the PC, sleeping.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic [1:0]  rs_used_id,
  input  logic [4:0]  rd_id_ex,
  input  logic        load_id_ex,
  input  logic        jump_ex,
  input  logic [31:0] jump_addr_ex,
  input  logic        exception_id,
  input  logic        irq_pending,
  input  logic        wfi_ex,
  input  logic        mem_busy,
  input  logic        trap_ack,
  input  logic [31:0] trap_vec,
  output logic        stall_n_if,
  output logic        stall_n_id,
  output logic        hold_if_id,
  output logic        hold_id_ex,
  output logic        pc_load,
  output logic [31:0] pc_load_addr,
  output logic        trap_req,
  output logic        trap_cause,
  output logic        sleeping
);

  // Extra bubbles after the first one, which is issued from RUN.
  localparam logic [1:0] LU_EXTRA = 2'(LOAD_USE_BUBBLES - 1);

  pipe_state_e state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  trap_cause_e cause_q, cause_d;
  logic        lu_hazard;

  load_use_detect u_lud (
    .rs1_id     (rs1_id),
    .rs2_id     (rs2_id),
    .rs_used_id (rs_used_id),
    .rd_id_ex   (rd_id_ex),
    .load_id_ex (load_id_ex),
    .hazard_o   (lu_hazard)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
      cause_q <= CAUSE_EXC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cause_d      = cause_q;
    stall_n_if   = 1'b1;
    stall_n_id   = 1'b1;
    hold_if_id   = HOLD_PASS;
    hold_id_ex   = HOLD_PASS;
    pc_load      = 1'b0;
    pc_load_addr = jump_addr_ex;
    trap_req     = 1'b0;
    sleeping     = 1'b0;

    case (state_q)
      ST_RUN, ST_LU_STALL: begin
        if (mem_busy) begin
          // Freeze everything; redirects and traps wait until memory completes.
          stall_n_if = 1'b0;
          stall_n_id = 1'b0;
        end else if (jump_ex) begin
          // Younger instructions are wrong-path: flush both registers and drop
          // any exception, WFI or load-use they raised.
          pc_load    = 1'b1;
          hold_if_id = HOLD_NOP;
          hold_id_ex = HOLD_NOP;
          state_d    = ST_RUN;
          cnt_d      = 2'd0;
        end else if (exception_id || irq_pending) begin
          state_d    = ST_TRAP;
          cnt_d      = 2'd0;
          cause_d    = (irq_pending && !exception_id) ? CAUSE_IRQ : CAUSE_EXC;
          stall_n_if = 1'b0;
          hold_if_id = HOLD_NOP;
          hold_id_ex = HOLD_NOP;
        end else if ((state_q == ST_RUN) && wfi_ex) begin
          state_d    = ST_SLEEP;
          stall_n_if = 1'b0;
          hold_if_id = HOLD_NOP;
        end else if (state_q == ST_LU_STALL) begin
          // Keep bubbling regardless of the current hazard inputs until the
          // configured bubble count has been issued.
          stall_n_if = 1'b0;
          hold_id_ex = HOLD_NOP;
          cnt_d      = cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_d = ST_RUN;
          end
        end else if (lu_hazard) begin
          stall_n_if = 1'b0;
          hold_id_ex = HOLD_NOP;
          if (LOAD_USE_BUBBLES > 1) begin
            state_d = ST_LU_STALL;
            cnt_d   = LU_EXTRA;
          end
        end
      end

      ST_TRAP: begin
        trap_req   = 1'b1;
        stall_n_if = 1'b0;
        hold_if_id = HOLD_NOP;
        hold_id_ex = HOLD_NOP;
        if (trap_ack) begin
          // Handler entry wins over anything pending this cycle; a still-pending
          // IRQ is re-evaluated from RUN on the next cycle.
          pc_load      = 1'b1;
          pc_load_addr = trap_vec;
          state_d      = ST_RUN;
        end
      end

      ST_SLEEP: begin
        sleeping   = 1'b1;
        stall_n_if = 1'b0;
        stall_n_id = 1'b0;
        hold_if_id = HOLD_NOP;
        if (irq_pending) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_IRQ;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Reset forces the safe output set without waiting for a clock edge.
    if (!rst_n) begin
      stall_n_if = 1'b0;
      stall_n_id = 1'b0;
      hold_if_id = HOLD_NOP;
      hold_id_ex = HOLD_NOP;
      pc_load    = 1'b0;
      trap_req   = 1'b0;
      sleeping   = 1'b0;
    end
  end

  assign trap_cause = cause_q;

endmodule : pipeline_ctrl
